// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 initiator (spi_master_tx).
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    WAIT  = 3'd4,
    HOLD  = 3'd5,
    GAP   = 3'd6
  } spi_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Byte-stream and status bundle between a host (master modport) and spi_master_tx (slave modport).
interface spi_master_tx_if;
  import spi_pkg::*;

  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_last;
  logic                  rx_valid;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data, busy
  );

endinterface

// File: rtl/spi_clk_div.sv
// Loadable down-counter; tick_o is high in the last cycle of each loaded phase length.
module spi_clk_div #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == W'(1));

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: byte stream in, SCK/SSEL/MOSI out, MISO captured into an rx byte pulse.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first in both directions (default MSB first).
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_tx_if.slave   bus,
  output logic             sck_o,
  output logic             ssel_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  // One divider times every phase, so it must hold the longest of them.
  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_IDLE) + 1);

  spi_state_e            state_q, state_d;
  logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic                  last_q, last_d;
  logic                  sck_q, sck_d;
  logic                  ssel_q, ssel_d;
  logic                  mosi_q, mosi_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rdy_en_q;
  logic [1:0]            miso_sync_q;
  logic                  miso_s;
  logic                  accept;
  logic                  div_load;
  logic [CNT_W-1:0]      div_val;
  logic                  div_tick;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic [SPI_BYTE_W-1:0] tx_shift(input logic [SPI_BYTE_W-1:0] d);
    return {1'b0, d[SPI_BYTE_W-1:1]};
  endfunction
  function automatic logic out_bit(input logic [SPI_BYTE_W-1:0] d);
    return d[0];
  endfunction
  function automatic logic [SPI_BYTE_W-1:0] rx_shift(input logic [SPI_BYTE_W-1:0] d, input logic b);
    return {b, d[SPI_BYTE_W-1:1]};
  endfunction
`else
  function automatic logic [SPI_BYTE_W-1:0] tx_shift(input logic [SPI_BYTE_W-1:0] d);
    return {d[SPI_BYTE_W-2:0], 1'b0};
  endfunction
  function automatic logic out_bit(input logic [SPI_BYTE_W-1:0] d);
    return d[SPI_BYTE_W-1];
  endfunction
  function automatic logic [SPI_BYTE_W-1:0] rx_shift(input logic [SPI_BYTE_W-1:0] d, input logic b);
    return {d[SPI_BYTE_W-2:0], b};
  endfunction
`endif

  spi_clk_div #(.W(CNT_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .load_val_i (div_val),
    .tick_o     (div_tick)
  );

  assign miso_s       = miso_sync_q[1];
  assign bus.tx_ready = ((state_q == IDLE) && rdy_en_q) || (state_q == WAIT);
  assign accept       = bus.tx_valid && bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bitcnt_d   = bitcnt_q;
    last_d     = last_q;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    div_load   = 1'b0;
    div_val    = CNT_W'(CLK_DIV);
    case (state_q)
      IDLE, WAIT: if (accept) begin
        tx_sh_d  = bus.tx_data;
        last_d   = bus.tx_last;
        bitcnt_d = '0;
        mosi_d   = out_bit(bus.tx_data);
        ssel_d   = 1'b0;
        div_load = 1'b1;
        // Continuation bytes skip the chip-select setup phase.
        if (state_q == IDLE) begin
          state_d = SETUP;
          div_val = CNT_W'(CS_SETUP);
        end else begin
          state_d = LOW;
        end
      end
      SETUP: if (div_tick) begin
        state_d  = LOW;
        div_load = 1'b1;
      end
      LOW: if (div_tick) begin
        state_d  = HIGH;
        sck_d    = 1'b1;
        rx_sh_d  = rx_shift(rx_sh_q, miso_s);
        div_load = 1'b1;
      end
      HIGH: if (div_tick) begin
        sck_d = 1'b0;
        if (bitcnt_q != 3'd7) begin
          state_d  = LOW;
          bitcnt_d = bitcnt_q + 3'd1;
          tx_sh_d  = tx_shift(tx_sh_q);
          mosi_d   = out_bit(tx_shift(tx_sh_q));
          div_load = 1'b1;
        end else begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
          if (last_q) begin
            state_d  = HOLD;
            div_load = 1'b1;
            div_val  = CNT_W'(CS_SETUP);
          end else begin
            state_d = WAIT;
          end
        end
      end
      HOLD: if (div_tick) begin
        state_d  = GAP;
        ssel_d   = 1'b1;
        div_load = 1'b1;
        div_val  = CNT_W'(CS_IDLE);
      end
      GAP: if (div_tick) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      bitcnt_q    <= '0;
      last_q      <= 1'b0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
      miso_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      bitcnt_q    <= bitcnt_d;
      last_q      <= last_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      mosi_q      <= mosi_d;
      rx_valid_q  <= rx_valid_d;
      rdy_en_q    <= 1'b1;
      miso_sync_q <= {miso_sync_q[0], miso_i};
    end
  end

  assign sck_o        = sck_q;
  assign ssel_o       = ssel_q;
  assign mosi_o       = mosi_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_master_tx.sv
// Randomised bench for spi_master_tx against a bit-order/framing reference model.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_IDLE  = 2;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck, ssel, mosi, miso;
  int   miso_mode = 0;   // 0 loopback, 1 tied high, 2 tied low

  always #5 clk = ~clk;

  spi_master_tx_if bus ();

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

  spi_master_tx #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .sck_o  (sck),
    .ssel_o (ssel),
    .mosi_o (mosi),
    .miso_i (miso)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmit order of a byte packed so that bit 7 is the first bit on the wire.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[7-i] = LSB_FIRST ? b[i] : b[7-i];
    return w;
  endfunction

  function automatic logic [7:0] exp_rx(input logic [7:0] b, input int mode);
    return (mode == 0) ? b : ((mode == 1) ? 8'hFF : 8'h00);
  endfunction

  // Line monitor, sampled on the falling clk edge.
  logic       bit_q[$];
  logic [7:0] rx_q[$];
  int   rise_cnt = 0;
  int   acc_cnt  = 0;
  logic prev_sck = 1'b0, prev_ssel = 1'b1;
  int   since_rise = 0, since_sck_fall = 0, since_ssel_fall = 0, ssel_hi_len = 100;
  bit   first_rise_pending = 1'b0;

  always @(posedge clk) if (!rst && bus.tx_valid && bus.tx_ready) acc_cnt <= acc_cnt + 1;

  always @(negedge clk) begin
    prev_sck        <= sck;
    prev_ssel       <= ssel;
    since_rise      <= since_rise + 1;
    since_sck_fall  <= since_sck_fall + 1;
    since_ssel_fall <= since_ssel_fall + 1;
    ssel_hi_len     <= ssel_hi_len + 1;
    if (rst) begin
      first_rise_pending <= 1'b0;
      ssel_hi_len        <= 100;
      rise_cnt           <= 0;
    end else begin
      if (bus.rx_valid) rx_q.push_back(bus.rx_data);
      if (prev_ssel && !ssel) begin
        check_eq("cs_idle_min", (ssel_hi_len + 1) >= CS_IDLE, 1);
        since_ssel_fall    <= 0;
        first_rise_pending <= 1'b1;
      end
      if (!prev_sck && sck) begin
        check_eq("sck_rise_ssel", ssel, 0);
        if (first_rise_pending) begin
          check_eq("cs_setup_lat", since_ssel_fall + 1, CS_SETUP + CLK_DIV);
          first_rise_pending <= 1'b0;
        end else if (rise_cnt % 8 != 0) begin
          check_eq("sck_low_len", since_sck_fall + 1, CLK_DIV);
        end
        bit_q.push_back(mosi);
        rise_cnt   <= rise_cnt + 1;
        since_rise <= 0;
      end
      if (prev_sck && !sck) begin
        check_eq("sck_high_len", since_rise + 1, CLK_DIV);
        check_eq("sck_fall_ssel", ssel, 0);
        since_sck_fall <= 0;
      end
      if (!prev_ssel && ssel) begin
        check_eq("cs_hold", since_sck_fall + 1, CS_SETUP);
        ssel_hi_len <= 0;
      end
    end
  end

  logic [7:0] tx_q[$];

  task automatic send_byte(input logic [7:0] d, input logic last, input int max_gap, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    @(negedge clk);
    while (!bus.tx_ready) begin
      n++;
      if (n > 4000) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check_eq("tx_ready_seen", ok, 1);
    if (!ok) return;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = last;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
  endtask

  task automatic run_txn(input bit toggle, input int max_gap);
    int rb, bb, xb, ab, n, t;
    bit ok;
    logic [7:0] o;
    rb = rise_cnt; bb = bit_q.size(); xb = rx_q.size(); ab = acc_cnt; n = tx_q.size(); t = 0;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_byte(tx_q[i], (i == n - 1), max_gap, ok);
      if (!ok) break;
    end
    // Drain; optionally keep offering junk bytes while the frame is active.
    do begin
      @(negedge clk);
      t++;
      if (toggle) begin
        if (!ssel) begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = 8'($urandom);
        end else begin
          bus.tx_valid = 1'b0;
        end
      end
    end while (bus.busy && t < 5000);
    bus.tx_valid = 1'b0;
    check_eq("drain_done", bus.busy, 0);
    check_eq("ssel_idle", ssel, 1);
    check_eq("sck_rises", rise_cnt - rb, 8 * n);
    check_eq("rx_count", rx_q.size() - xb, n);
    check_eq("accepts", acc_cnt - ab, n);
    for (int i = 0; i < n; i++) begin
      if (bit_q.size() >= bb + 8 * (i + 1)) begin
        o = '0;
        for (int k = 0; k < 8; k++) o = {o[6:0], bit_q[bb + 8 * i + k]};
        check_eq("mosi_byte", o, wire_order(tx_q[i]));
      end
      if (rx_q.size() > xb + i) check_eq("rx_byte", rx_q[xb + i], exp_rx(tx_q[i], miso_mode));
    end
    $display("txn: %0d byte(s) first 0x%02h miso_mode %0d toggle %0d", n, tx_q[0], miso_mode, toggle);
  endtask

  initial begin
    int t, rb, xb;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.tx_last  = 1'b0;

    // Reset values and tx_ready release.
    repeat (3) @(negedge clk);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_ssel", ssel, 1);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_ready", bus.tx_ready, 0);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_rx_data", bus.rx_data, 0);
    check_eq("rst_busy", bus.busy, 0);
    #2 rst = 1'b0;
    #1 check_eq("ready_before_clk", bus.tx_ready, 0);
    @(posedge clk);
    #1 check_eq("ready_after_clk", bus.tx_ready, 1);

    tx_q = '{8'hCC};       run_txn(1'b0, 0);
    tx_q = '{8'hA5, 8'h3C}; run_txn(1'b0, 0);
    tx_q = '{8'h5A};       run_txn(1'b1, 0);
    tx_q = '{8'h01};       run_txn(1'b0, 0);

    // Reset in the middle of a 0xDD byte, then a clean retry.
    rb = rise_cnt; xb = rx_q.size(); t = 0;
    tx_q = '{8'hDD};
    begin
      bit ok;
      send_byte(8'hDD, 1'b1, 0, ok);
    end
    while (rise_cnt - rb < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("rise3_reached", rise_cnt - rb, 3);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_sck", sck, 0);
    check_eq("midrst_ssel", ssel, 1);
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_rx_valid", bus.rx_valid, 0);
    repeat (3) @(negedge clk);
    check_eq("midrst_no_rx", rx_q.size() - xb, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check_eq("midrst_ready", bus.tx_ready, 1);
    run_txn(1'b0, 0);

    miso_mode = 1; tx_q = '{8'($urandom)}; run_txn(1'b0, 0);
    miso_mode = 2; tx_q = '{8'($urandom)}; run_txn(1'b0, 0);
    miso_mode = 0;

    for (int r = 0; r < 12; r++) begin
      int nb;
      nb = $urandom_range(1, 3);
      tx_q.delete();
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
      miso_mode = $urandom_range(0, 2);
      run_txn(1'($urandom_range(0, 1)), 12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
